// File: rtl/pipeline_control_if.sv
// Pipeline-side bundle for the stall/flush controller.
// It carries the stage-buffer status fields, the memory handshakes and the buffer load/flush controls.
interface pipeline_control_if;
    logic [2:0] id_src1;
    logic [2:0] id_src2;
    logic       id_uses_src1;
    logic       id_uses_src2;
    logic [2:0] ex_dest;
    logic       ex_is_load;
    logic       ex_regwrite;
    logic       br_taken;
    logic       imem_resp;
    logic       dmem_req;
    logic       dmem_resp;

    logic       imem_read;
    logic       load_pc;
    logic       pcmux_sel;
    logic       load_if_id;
    logic       load_id_ex;
    logic       load_ex_mem;
    logic       load_mem_wb;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       flush_ex_mem;

    // The controller side drives the buffer controls.
    modport master (
        input  id_src1, id_src2, id_uses_src1, id_uses_src2, ex_dest,
               ex_is_load, ex_regwrite, br_taken, imem_resp, dmem_req, dmem_resp,
        output imem_read, load_pc, pcmux_sel, load_if_id, load_id_ex, load_ex_mem,
               load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem
    );

    modport slave (
        output id_src1, id_src2, id_uses_src1, id_uses_src2, ex_dest,
               ex_is_load, ex_regwrite, br_taken, imem_resp, dmem_req, dmem_resp,
        input  imem_read, load_pc, pcmux_sel, load_if_id, load_id_ex, load_ex_mem,
               load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem
    );
endinterface

// File: rtl/pipeline_control.sv
// Stall, flush and bubble controller for the 5-stage LC-3b pipeline.
// It also tracks memory waits with a sticky watchdog and keeps saturating performance counters.
module pipeline_control #(
    parameter int TIMEOUT   = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_control_if.master    pipe,
    input  logic                  count_clear,
    output logic                  mem_timeout,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  bubble_count,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt, wait_d;
    logic              fetch_req;
    logic              memstall;
    logic              hazard;
    logic              do_stall, do_redirect, do_bubble;
    logic              timeout_hit;

    assign fetch_req = !reset;
    assign memstall  = (fetch_req && !pipe.imem_resp) || (pipe.dmem_req && !pipe.dmem_resp);
    assign hazard    = pipe.ex_is_load && pipe.ex_regwrite &&
                       ((pipe.id_uses_src1 && (pipe.id_src1 == pipe.ex_dest)) ||
                        (pipe.id_uses_src2 && (pipe.id_src2 == pipe.ex_dest)));

    // A memory stall freezes everything, so a redirect or a bubble only takes effect once it ends.
    assign do_stall    = !reset && memstall;
    assign do_redirect = !reset && !memstall && pipe.br_taken;
    assign do_bubble   = !reset && !memstall && !pipe.br_taken && hazard;

    // NOTE: every output gets a default before the priority chain, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        pipe.imem_read    = fetch_req;
        pipe.load_pc      = 1'b1;
        pipe.pcmux_sel    = 1'b0;
        pipe.load_if_id   = 1'b1;
        pipe.load_id_ex   = 1'b1;
        pipe.load_ex_mem  = 1'b1;
        pipe.load_mem_wb  = 1'b1;
        pipe.flush_if_id  = 1'b0;
        pipe.flush_id_ex  = 1'b0;
        pipe.flush_ex_mem = 1'b0;
        if (reset) begin
            pipe.load_pc      = 1'b0;
            pipe.load_if_id   = 1'b0;
            pipe.load_id_ex   = 1'b0;
            pipe.load_ex_mem  = 1'b0;
            pipe.load_mem_wb  = 1'b0;
            pipe.flush_if_id  = 1'b1;
            pipe.flush_id_ex  = 1'b1;
            pipe.flush_ex_mem = 1'b1;
        end else if (do_stall) begin
            pipe.load_pc     = 1'b0;
            pipe.load_if_id  = 1'b0;
            pipe.load_id_ex  = 1'b0;
            pipe.load_ex_mem = 1'b0;
            pipe.load_mem_wb = 1'b0;
        end else if (do_redirect) begin
            pipe.pcmux_sel    = 1'b1;
            pipe.flush_if_id  = 1'b1;
            pipe.flush_id_ex  = 1'b1;
            pipe.flush_ex_mem = 1'b1;
        end else if (do_bubble) begin
            // Hold PC and ID, and push a NOP into EX in place of the dependent instruction.
            pipe.load_pc     = 1'b0;
            pipe.load_if_id  = 1'b0;
            pipe.flush_id_ex = 1'b1;
        end
    end

    // The first stall cycle counts as wait cycle 1, so the watchdog trips after TIMEOUT consecutive stall cycles.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_cnt;
        unique case (state_q)
            RUN: begin
                if (memstall) begin
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!memstall) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_d = wait_cnt + WAIT_W'(1);
                end
            end
        endcase
    end

    assign timeout_hit = (wait_d == WAIT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_d;
            if (count_clear) begin
                mem_timeout  <= 1'b0;
                stall_cycles <= '0;
                bubble_count <= '0;
                flush_count  <= '0;
            end else begin
                if (timeout_hit)
                    mem_timeout <= 1'b1;
                if (do_stall && stall_cycles != '1)
                    stall_cycles <= stall_cycles + CNT_WIDTH'(1);
                if (do_bubble && bubble_count != '1)
                    bubble_count <= bubble_count + CNT_WIDTH'(1);
                if (do_redirect && flush_count != '1)
                    flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Central stall, flush and bubble controller for the 5-stage LC-3b pipeline.
- Reads the register fields and status bits that the stage buffers present at their outputs (src/dest of ID and EX, load/regwrite flags).
- Drives the `load` and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB buffers, plus the PC load and the fetch request.
- Maintains a memory-wait state machine, a wait watchdog, and saturating performance counters.

Parameters:
- TIMEOUT, 64, number of consecutive MEM_WAIT cycles before `mem_timeout` sets.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_src1  in  3  SR1 of the instruction in ID (IF/ID buffer output).
- id_src2  in  3  SR2 of the instruction in ID.
- id_uses_src1  in  1  ID instruction reads src1.
- id_uses_src2  in  1  ID instruction reads src2.
- ex_dest  in  3  DR of the instruction in EX (ID/EX buffer output).
- ex_is_load  in  1  EX instruction is LDR/LDB/LDI.
- ex_regwrite  in  1  EX instruction writes the register file.
- br_taken  in  1  MEM-stage branch/JMP/JSR/TRAP redirect.
- imem_resp  in  1  instruction memory done.
- dmem_req  in  1  MEM stage requests data memory.
- dmem_resp  in  1  data memory done.
- count_clear  in  1  synchronous clear of the counters and `mem_timeout`.
- imem_read  out  1  fetch request.
- load_pc  out  1  PC register load.
- pcmux_sel  out  1  1 selects the branch target, 0 selects PC+2.
- load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  buffer loads.
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  buffer captures NOP/zeros when its flush and load are both 1.
- mem_timeout  out  1  sticky watchdog error.
- stall_cycles  out  CNT_WIDTH  memory-stall cycle count.
- bubble_count  out  CNT_WIDTH  load-use bubble count.
- flush_count  out  CNT_WIDTH  redirect count.

Behaviour:
- Definitions:
  - memstall = (imem_read & !imem_resp) | (dmem_req & !dmem_resp).
  - hazard = ex_is_load & ex_regwrite & ((id_uses_src1 & id_src1==ex_dest) | (id_uses_src2 & id_src2==ex_dest)).
- Control outputs are combinational from state and inputs, evaluated in the priority order below. Counters, state and `mem_timeout` are registered.
- P0, reset=1:
  - imem_read=0; all loads=0; pcmux_sel=0; all flushes=1.
  - Next edge: state=RUN, wait_cnt=0, all counters=0, mem_timeout=0.
- P1, memstall=1:
  - imem_read=1; all loads=0; all flushes=0; pcmux_sel=0.
  - br_taken and hazard are ignored (held) this cycle. This is a full freeze, so no buffer changes.
- P2, br_taken=1:
  - All loads=1; pcmux_sel=1; flush_if_id, flush_id_ex and flush_ex_mem all =1. This squashes three younger instructions.
  - The redirect overrides any simultaneous hazard.
- P3, hazard=1:
  - load_pc=0, load_if_id=0 (ID held).
  - load_id_ex=1 with flush_id_ex=1, inserting one bubble.
  - load_ex_mem=1, load_mem_wb=1.
  - The bubble clears the hazard next cycle, so each load-use costs exactly 1 cycle.
- P4, otherwise: all loads=1, flushes=0, pcmux_sel=0.
- imem_read=1 whenever reset=0.
- State machine:
  - RUN→MEM_WAIT on memstall.
  - MEM_WAIT stays while memstall; wait_cnt increments each cycle, saturating at TIMEOUT.
  - MEM_WAIT→RUN on !memstall; wait_cnt is reset to 0.
  - When wait_cnt reaches TIMEOUT, mem_timeout=1, sticky until reset or count_clear. Completing later does not clear it.
- Counters:
  - stall_cycles +1 per memstall cycle.
  - bubble_count +1 per P3 cycle.
  - flush_count +1 per P2 cycle.
  - All saturate at all-ones and never wrap.
  - count_clear zeroes the counters and mem_timeout at the next edge, taking precedence over any increment that cycle. It does not affect control outputs or state.
- Reset mid-stall: state returns to RUN and wait_cnt=0 regardless of the pending response.
- Register R0 is a valid hazard target; there is no special case for it.

Test Plan:
- Reset held 2 cycles, then released with resps=1 and no hazard → during reset all loads=0 and flushes=1; afterwards all loads=1, imem_read=1, counters=0.
- Pipeline load-use: ex_is_load=1, ex_regwrite=1, ex_dest=3, id_src1=3, id_uses_src1=1 → exactly 1 cycle with load_pc=0, load_if_id=0, load_id_ex=1 and flush_id_ex=1; bubble_count=1.
- br_taken=1 coincident with hazard → pcmux_sel=1, three flushes=1, all loads=1; flush_count=1, bubble_count unchanged.
- dmem_req=1 with dmem_resp low for 5 cycles and br_taken=1 throughout → 5 frozen cycles, then the redirect in cycle 6; stall_cycles=5, state back to RUN.
- imem_resp low for 70 cycles with TIMEOUT=64 → mem_timeout rises on the 64th wait cycle and stays 1 after the response; count_clear → mem_timeout=0 and counters=0.
- Counter saturation with CNT_WIDTH=4 and 20 stall cycles → stall_cycles holds at 15.
